execute_cycle_stage: RTL and testbench

//  Execute stage of the 5-stage pipelined RV32 core: operand forwarding muxes, ALU, branch/jump

---
 rtl/execute_cycle_stage.sv | 128 ++++++++++++
 tb/tb_execute_cycle_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_cycle_stage.sv
// Execute stage of the 5-stage RV32 pipeline: forwarding muxes, ALU, branch/jump decision
// and the EX/MEM pipeline register feeding the memory stage.
module execute_cycle_stage #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               RegWriteE,
    input  logic               ResultSrcE,
    input  logic               MemWriteE,
    input  logic               JumpE,
    input  logic               BranchE,
    input  logic               ALUSrcE,
    input  logic [2:0]         ALUControlE,
    input  logic [DATA_W-1:0]  RD1E,
    input  logic [DATA_W-1:0]  RD2E,
    input  logic [DATA_W-1:0]  ImmExtE,
    input  logic [DATA_W-1:0]  PCE,
    input  logic [DATA_W-1:0]  PCPlus4E,
    input  logic [RADDR_W-1:0] RdE,
    input  logic [DATA_W-1:0]  ResultW,
    input  logic [1:0]         ForwardAE,
    input  logic [1:0]         ForwardBE,
    output logic               PCSrcE,
    output logic [DATA_W-1:0]  PCTargetE,
    output logic               RegWriteM,
    output logic               ResultSrcM,
    output logic               MemWriteM,
    output logic [DATA_W-1:0]  ALUResultM,
    output logic [DATA_W-1:0]  WriteDataM,
    output logic [DATA_W-1:0]  PCPlus4M,
    output logic [RADDR_W-1:0] RdM
);

    logic [DATA_W-1:0]  src_a_c;
    logic [DATA_W-1:0]  write_data_c;
    logic [DATA_W-1:0]  src_b_c;
    logic [DATA_W-1:0]  alu_result_c;
    logic               zero_c;

    logic               reg_write_d,   reg_write_q;
    logic               result_src_d,  result_src_q;
    logic               mem_write_d,   mem_write_q;
    logic [DATA_W-1:0]  alu_result_d,  alu_result_q;
    logic [DATA_W-1:0]  write_data_d,  write_data_q;
    logic [DATA_W-1:0]  pc_plus4_d,    pc_plus4_q;
    logic [RADDR_W-1:0] rd_d,          rd_q;

    // Forwarding: code 10 takes the value currently held in the EX/MEM register
    always_comb begin
        src_a_c = RD1E;
        case (ForwardAE)
            2'b01:   src_a_c = ResultW;
            2'b10:   src_a_c = alu_result_q;
            default: src_a_c = RD1E;
        endcase
    end

    always_comb begin
        write_data_c = RD2E;
        case (ForwardBE)
            2'b01:   write_data_c = ResultW;
            2'b10:   write_data_c = alu_result_q;
            default: write_data_c = RD2E;
        endcase
    end

    assign src_b_c = ALUSrcE ? ImmExtE : write_data_c;

    always_comb begin
        alu_result_c = '0;
        case (ALUControlE)
            3'b000:  alu_result_c = src_a_c + src_b_c;
            3'b001:  alu_result_c = src_a_c - src_b_c;
            3'b010:  alu_result_c = src_a_c & src_b_c;
            3'b011:  alu_result_c = src_a_c | src_b_c;
            3'b100:  alu_result_c = src_a_c ^ src_b_c;
            3'b101:  alu_result_c = DATA_W'($signed(src_a_c) < $signed(src_b_c));
            3'b110:  alu_result_c = DATA_W'(src_a_c < src_b_c);
            default: alu_result_c = '0;
        endcase
    end

    assign zero_c    = (alu_result_c == '0);
    assign PCSrcE    = (BranchE & zero_c) | JumpE;
    assign PCTargetE = PCE + ImmExtE;

    always_comb begin
        reg_write_d  = RegWriteE;
        result_src_d = ResultSrcE;
        mem_write_d  = MemWriteE;
        alu_result_d = alu_result_c;
        write_data_d = write_data_c;
        pc_plus4_d   = PCPlus4E;
        rd_d         = RdE;
    end

    // EX/MEM register: no enable, bubbles arrive as zeroed controls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_q  <= 1'b0;
            result_src_q <= 1'b0;
            mem_write_q  <= 1'b0;
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_plus4_q   <= '0;
            rd_q         <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            mem_write_q  <= mem_write_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            pc_plus4_q   <= pc_plus4_d;
            rd_q         <= rd_d;
        end
    end

    assign RegWriteM  = reg_write_q;
    assign ResultSrcM = result_src_q;
    assign MemWriteM  = mem_write_q;
    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign PCPlus4M   = pc_plus4_q;
    assign RdM        = rd_q;

endmodule

// File: tb/tb_execute_cycle_stage.sv
// Bench for execute_cycle_stage: directed cases plus random traffic against a
// behavioural model of the execute stage and EX/MEM register.
module tb_execute_cycle_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW;
    logic [4:0]  RdE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, ResultSrcM, MemWriteM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the EX/MEM register contents
    logic        m_regwrite, m_resultsrc, m_memwrite;
    logic [31:0] m_alu, m_wd, m_pc4;
    logic [4:0]  m_rd;

    execute_cycle_stage #(.DATA_W(32), .RADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RdE(RdE), .ResultW(ResultW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rf,
                                        input logic [31:0] wb, input logic [31:0] mem);
        if (sel == 2'd1) return wb;
        if (sel == 2'd2) return mem;
        return rf;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
            3'd6:    return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_m(input string ctx);
        chk({ctx, ".RegWriteM"},  32'(RegWriteM),  32'(m_regwrite));
        chk({ctx, ".ResultSrcM"}, 32'(ResultSrcM), 32'(m_resultsrc));
        chk({ctx, ".MemWriteM"},  32'(MemWriteM),  32'(m_memwrite));
        chk({ctx, ".ALUResultM"}, ALUResultM,      m_alu);
        chk({ctx, ".WriteDataM"}, WriteDataM,      m_wd);
        chk({ctx, ".PCPlus4M"},   PCPlus4M,        m_pc4);
        chk({ctx, ".RdM"},        32'(RdM),        32'(m_rd));
    endtask

    function automatic logic exp_pcsrc();
        logic [31:0] a, wd, b, r;
        a  = fwd(ForwardAE, RD1E, ResultW, m_alu);
        wd = fwd(ForwardBE, RD2E, ResultW, m_alu);
        b  = ALUSrcE ? ImmExtE : wd;
        r  = alu_ref(ALUControlE, a, b);
        return (BranchE && (r == 32'd0)) || JumpE;
    endfunction

    // Check same-cycle outputs, clock one edge, then check the registered outputs
    task automatic step(input string ctx);
        logic [31:0] a, wd, b, r;
        a  = fwd(ForwardAE, RD1E, ResultW, m_alu);
        wd = fwd(ForwardBE, RD2E, ResultW, m_alu);
        b  = ALUSrcE ? ImmExtE : wd;
        r  = alu_ref(ALUControlE, a, b);
        #1;
        chk({ctx, ".PCSrcE"},    32'(PCSrcE), 32'(exp_pcsrc()));
        chk({ctx, ".PCTargetE"}, PCTargetE,   PCE + ImmExtE);
        @(posedge clk);
        #1;
        m_regwrite  = RegWriteE;
        m_resultsrc = ResultSrcE;
        m_memwrite  = MemWriteE;
        m_alu       = r;
        m_wd        = wd;
        m_pc4       = PCPlus4E;
        m_rd        = RdE;
        check_m(ctx);
    endtask

    task automatic clear_inputs();
        RegWriteE = 0; ResultSrcE = 0; MemWriteE = 0; JumpE = 0; BranchE = 0; ALUSrcE = 0;
        ALUControlE = 3'd0; RD1E = 0; RD2E = 0; ImmExtE = 0; PCE = 0; PCPlus4E = 0;
        RdE = 0; ResultW = 0; ForwardAE = 2'd0; ForwardBE = 2'd0;
    endtask

    task automatic model_clear();
        m_regwrite = 0; m_resultsrc = 0; m_memwrite = 0;
        m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0;
    endtask

    // Assert reset between edges, hold it across one edge, release before the next
    task automatic rst_pulse(input string ctx);
        #2 rst = 1'b1;
        #1;
        model_clear();
        check_m({ctx, ".async"});
        @(posedge clk);
        #1;
        check_m({ctx, ".held"});
        rst = 1'b0;
    endtask

    task automatic randomize_inputs();
        RegWriteE   = 1'($urandom);
        ResultSrcE  = 1'($urandom);
        MemWriteE   = 1'($urandom);
        JumpE       = ($urandom_range(0, 5) == 0);
        BranchE     = 1'($urandom);
        ALUSrcE     = 1'($urandom);
        ALUControlE = 3'($urandom);
        RD1E        = $urandom;
        RD2E        = ($urandom_range(0, 3) == 0) ? RD1E : $urandom;
        ImmExtE     = $urandom;
        PCE         = $urandom;
        PCPlus4E    = PCE + 32'd4;
        RdE         = 5'($urandom);
        ResultW     = $urandom;
        ForwardAE   = 2'($urandom);
        ForwardBE   = 2'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_clear();
        #1;
        check_m("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_m("reset_hold");
        rst = 1'b0;

        // add
        RD1E = 32'd5; RD2E = 32'd7; RdE = 5'd3; RegWriteE = 1; PCPlus4E = 32'h104;
        step("add");
        chk("add.lit_alu", ALUResultM, 32'd12);
        chk("add.lit_rd", 32'(RdM), 32'd3);

        // forward: first seed ALUResultM = 0x20
        clear_inputs();
        RD1E = 32'h20;
        step("fwd_seed");
        ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'h11; ALUSrcE = 1; ImmExtE = 32'd4;
        RD1E = 32'hDEAD; RD2E = 32'hBEEF;
        step("fwd");
        chk("fwd.lit_alu", ALUResultM, 32'h24);
        chk("fwd.lit_wd", WriteDataM, 32'h11);

        // beq / jal decision, combinational
        clear_inputs();
        RD1E = 32'd9; RD2E = 32'd9; ALUControlE = 3'b001; BranchE = 1;
        PCE = 32'h40; ImmExtE = 32'hFFFF_FFF8;
        #1;
        chk("beq_taken", 32'(PCSrcE), 32'd1);
        chk("beq_target", PCTargetE, 32'h38);
        RD2E = 32'd8;
        #1;
        chk("beq_not_taken", 32'(PCSrcE), 32'd0);
        JumpE = 1;
        #1;
        chk("jal_taken", 32'(PCSrcE), 32'd1);
        step("beq_jal");

        // slt vs sltu, sub wrap
        clear_inputs();
        RD1E = 32'hFFFF_FFFF; RD2E = 32'd1; ALUControlE = 3'b101;
        step("slt");
        chk("slt.lit", ALUResultM, 32'd1);
        ALUControlE = 3'b110;
        step("sltu");
        chk("sltu.lit", ALUResultM, 32'd0);
        RD1E = 32'd0; ALUControlE = 3'b001;
        step("sub_wrap");
        chk("sub_wrap.lit", ALUResultM, 32'hFFFF_FFFF);
        ALUControlE = 3'b111; RD1E = 32'h1234;
        step("op111");
        chk("op111.lit", ALUResultM, 32'd0);

        // store
        clear_inputs();
        MemWriteE = 1; ALUSrcE = 1; ImmExtE = 32'd6; RD2E = 32'hA;
        step("store");
        chk("store.lit_alu", ALUResultM, 32'd6);
        chk("store.lit_wd", WriteDataM, 32'hA);
        chk("store.lit_mw", 32'(MemWriteM), 32'd1);

        // reset mid-stream, then next edge loads inputs normally
        clear_inputs();
        RegWriteE = 1; RdE = 5'd7; RD1E = 32'd3; RD2E = 32'd4; PCPlus4E = 32'h88;
        step("pre_rst");
        rst_pulse("mid_rst");
        RD1E = 32'd10; RD2E = 32'd20;
        step("post_rst");
        chk("post_rst.lit_alu", ALUResultM, 32'd30);

        // random traffic, including forwarding from the model's EX/MEM value
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            step("rand");
            if ($urandom_range(0, 40) == 0) rst_pulse("rand_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
